// File: rtl/scale_pipe.sv
// Per-lane fixed-point scaler for attention scores: stage 1 multiplies, stage 2 rounds,
// shifts and saturates. Two registered stages with valid/ready backpressure.
module scale_pipe #(
  parameter int unsigned LANES = 8,
  parameter int unsigned DW    = 8,
  parameter int unsigned SW    = 10,
  parameter int unsigned FRAC  = 8,
  parameter int unsigned CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW-1:0]         cfg_scale,
  input  logic                  cfg_round,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_sat,
  output logic [CNTW-1:0]       beat_cnt,
  output logic                  busy
);

  localparam int unsigned PW = DW + SW;
  localparam logic [PW:0] Rnd  = (PW + 1)'(1) << (FRAC - 1);
  localparam logic [PW:0] MaxV = {{(PW + 1 - DW){1'b0}}, {DW{1'b1}}};

  logic                r_s1_valid;
  logic                r_s1_round;
  logic [PW-1:0]       r_s1_prod [LANES];
  logic                r_out_valid;
  logic [LANES*DW-1:0] r_out_data;
  logic [LANES-1:0]    r_out_sat;
  logic [CNTW-1:0]     r_beat_cnt;

  logic                w_adv1;
  logic                w_adv2;
  logic                w_acc;
  logic [PW:0]         w_t;
  logic [PW:0]         w_q;
  logic [LANES*DW-1:0] w_s2_data;
  logic [LANES-1:0]    w_s2_sat;

  // Valids never look at the partner's ready; only the readies chain backwards.
  assign w_adv2   = !r_out_valid || out_ready;
  assign w_adv1   = !r_s1_valid || w_adv2;
  assign w_acc    = in_valid && w_adv1;
  assign in_ready = w_adv1;

  always_comb begin
    w_s2_data = '0;
    w_s2_sat  = '0;
    w_t       = '0;
    w_q       = '0;
    for (int i = 0; i < LANES; i++) begin
      w_t = {1'b0, r_s1_prod[i]} + (r_s1_round ? Rnd : '0);
      w_q = w_t >> FRAC;
      if (w_q > MaxV) begin
        w_s2_data[i*DW +: DW] = '1;
        w_s2_sat[i]           = 1'b1;
      end else begin
        w_s2_data[i*DW +: DW] = w_q[DW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_round  <= 1'b0;
      for (int i = 0; i < LANES; i++) r_s1_prod[i] <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_adv1) begin
        r_s1_valid <= w_acc;
        if (w_acc) begin
          r_s1_round <= cfg_round;
          for (int i = 0; i < LANES; i++) begin
            r_s1_prod[i] <= PW'(in_data[i*DW +: DW]) * PW'(cfg_scale);
          end
        end
      end
      // Data and flags hold when the stage drains so a bubble leaves the last bar visible.
      if (w_adv2) begin
        r_out_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_data <= w_s2_data;
          r_out_sat  <= w_s2_sat;
        end
      end
      if (r_out_valid && out_ready) r_beat_cnt <= r_beat_cnt + CNTW'(1);
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_sat   = r_out_sat;
  assign beat_cnt  = r_beat_cnt;
  assign busy      = r_s1_valid || r_out_valid;

endmodule

// File: tb/tb_scale_pipe.sv
// Directed bench for scale_pipe: rounding, saturation, backpressure, config change,
// counter wrap (CNTW=4) and asynchronous reset.
module tb_scale_pipe;

  localparam int unsigned LANES = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned SW    = 10;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned CNTW  = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [SW-1:0]       cfg_scale;
  logic                cfg_round;
  logic [LANES*DW-1:0] in_data;
  logic                in_valid;
  logic                in_ready;
  logic [LANES*DW-1:0] out_data;
  logic                out_valid;
  logic                out_ready;
  logic [LANES-1:0]    out_sat;
  logic [CNTW-1:0]     beat_cnt;
  logic                busy;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  scale_pipe #(
    .LANES(LANES), .DW(DW), .SW(SW), .FRAC(FRAC), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_scale(cfg_scale), .cfg_round(cfg_round),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sat(out_sat), .beat_cnt(beat_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  function automatic logic [63:0] rep(input logic [7:0] v);
    return {8{v}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single beat through an empty pipeline with out_ready=1; checks the 2-edge latency.
  task automatic xfer(input string tag, input logic [63:0] d, input logic [SW-1:0] sc,
                      input logic rnd, input logic [63:0] exp_d, input logic [7:0] exp_s);
    in_data   = d;
    cfg_scale = sc;
    cfg_round = rnd;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_ov_early"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    step();
    chk({tag, "_ov"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, exp_d);
    chk({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
    step();
    exp_cnt++;
  endtask

  int          bp_ir [14] = '{1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int          bp_ov [14] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  int          bp_od [14] = '{0, 0, 1, 2, 2, 2, 2, 2, 2, 3, 4, 5, 6, 0};
  int          bp_iv [14] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int          bp_id [14] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 5, 6, 0, 0, 0};
  logic [63:0] sat_in;
  logic [63:0] sat_out;

  initial begin
    rst_n     = 1'b0;
    cfg_scale = '0;
    cfg_round = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sat_in    = {8'd255, 8'd254, 8'd200, 8'd128, 8'd127, 8'd100, 8'd1, 8'd0};
    sat_out   = {8'd255, 8'd255, 8'd255, 8'd255, 8'd254, 8'd200, 8'd2, 8'd0};

    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    #10 rst_n = 1'b1;
    step();

    // 255*45 = 11475: truncate -> 44, round -> 45. 200*45 = 9000 -> 35 both ways.
    xfer("trunc255", rep(8'd255), 10'd45, 1'b0, rep(8'd44), 8'h00);
    xfer("round255", rep(8'd255), 10'd45, 1'b1, rep(8'd45), 8'h00);
    xfer("trunc200", rep(8'd200), 10'd45, 1'b0, rep(8'd35), 8'h00);
    xfer("round200", rep(8'd200), 10'd45, 1'b1, rep(8'd35), 8'h00);
    xfer("sat_x2", sat_in, 10'h200, 1'b0, sat_out, 8'hF0);
    xfer("scale0", rep(8'd255), 10'd0, 1'b1, rep(8'd0), 8'h00);
    xfer("ident_rnd", sat_in, 10'd256, 1'b1, sat_in, 8'h00);
    chk("cnt_after7", 64'(beat_cnt), 64'(exp_cnt % 16));

    // Back-to-back beats with different scales.
    in_data   = rep(8'd10);
    cfg_scale = 10'd256;
    cfg_round = 1'b0;
    in_valid  = 1'b1;
    step();
    cfg_scale = 10'd128;
    step();
    in_valid = 1'b0;
    chk("cfgchg_a", out_data, rep(8'd10));
    step();
    chk("cfgchg_b", out_data, rep(8'd5));
    chk("cfgchg_b_ov", 64'(out_valid), 64'd1);
    step();
    exp_cnt += 2;
    chk("cfgchg_drained", 64'(busy), 64'd0);

    // Six beats, out_ready low in cycles 3..7.
    cfg_scale = 10'd256;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 3 && c <= 7);
      in_valid  = (bp_iv[c] != 0);
      in_data   = rep(8'(bp_id[c]));
      #1;
      chk($sformatf("bp_ir_c%0d", c), 64'(in_ready), 64'(bp_ir[c]));
      chk($sformatf("bp_ov_c%0d", c), 64'(out_valid), 64'(bp_ov[c]));
      if (bp_ov[c] != 0) chk($sformatf("bp_od_c%0d", c), out_data, rep(8'(bp_od[c])));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    exp_cnt += 6;
    chk("bp_cnt15", 64'(beat_cnt), 64'(exp_cnt % 16));

    // Two more handshakes: 17 in total, 4-bit counter wraps to 1.
    xfer("wrap16", rep(8'd7), 10'd256, 1'b0, rep(8'd7), 8'h00);
    xfer("wrap17", rep(8'd9), 10'd256, 1'b0, rep(8'd9), 8'h00);
    chk("wrap_cnt", 64'(beat_cnt), 64'd1);
    chk("wrap_busy", 64'(busy), 64'd0);

    // Two beats in flight, stalled, then asynchronous reset mid-cycle.
    out_ready = 1'b0;
    in_data   = rep(8'd20);
    in_valid  = 1'b1;
    step();
    in_data = rep(8'd21);
    step();
    in_valid = 1'b0;
    chk("ar_pre_ov", 64'(out_valid), 64'd1);
    chk("ar_pre_ir", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ov", 64'(out_valid), 64'd0);
    chk("ar_cnt", 64'(beat_cnt), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_data", out_data, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("ar_rel_ir", 64'(in_ready), 64'd1);
    chk("ar_rel_ov", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/scale_pipe.md
Name: scale_pipe

Overview:
- Parametrised, runtime-configurable successor to the fixed 1/sqrt(d_k) scaler in the attention score path.
- Multiplies every unsigned lane of an input bar by a programmable fixed-point scale.
- Optionally rounds to nearest, then saturates.
- Two-stage pipeline with valid/ready backpressure; sits between the QK^T matmul output and softmax.

Parameters:
- LANES, 8, number of parallel lanes per bar.
- DW, 8, unsigned data width per lane (input and output).
- SW, 10, scale width (unsigned fixed point).
- FRAC, 8, fractional bits of the scale; real scale = cfg_scale / 2^FRAC; constraint 1 <= FRAC <= SW.
- CNTW, 16, width of the output beat counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_scale  in  SW  scale factor, sampled per accepted beat.
- cfg_round  in  1  1 = round half up before shift; 0 = truncate. Sampled per accepted beat.
- in_data  in  LANES*DW  input bar; lane i = in_data[i*DW +: DW].
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  LANES*DW  scaled bar, same lane packing as in_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_sat  out  LANES  per-lane flag: this lane saturated; qualified by out_valid.
- beat_cnt  out  CNTW  count of completed output handshakes.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset values (async, all outputs): out_data=0, out_valid=0, out_sat=0, beat_cnt=0, busy=0. in_ready=1 after reset (combinational).
- Input handshake: a beat is accepted on a rising edge when in_valid && in_ready. Output handshake: out_valid && out_ready. Neither valid may depend combinationally on the partner's ready.
- Stage 1 register (s1_valid, s1_prod[LANES], s1_round):
  - s1_prod[i] = in_lane[i] * cfg_scale, unsigned, DW+SW bits, lossless.
  - cfg_scale and cfg_round are captured with the beat. Changes mid-stream affect only subsequently accepted beats.
- Stage 2 (output) register, per lane:
  - t = s1_prod + (s1_round ? 2^(FRAC-1) : 0), computed in DW+SW+1 bits.
  - q = t >> FRAC.
  - If q > 2^DW-1: lane = 2^DW-1 and out_sat[i] = 1. Otherwise lane = q[DW-1:0] and out_sat[i] = 0.
- Flow control:
  - adv2 = !out_valid || out_ready.
  - adv1 = !s1_valid || adv2.
  - in_ready = adv1.
  - Stage 2 loads from stage 1 when adv2. If adv2 && !s1_valid, out_valid clears to 0; out_data and out_sat hold their values.
  - Stage 1 loads from the input when adv1. If adv1 and no beat is accepted, s1_valid clears.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+1, i.e. visible in the cycle following edge N+1. Throughput is 1 beat/cycle when out_ready=1.
- Stall: while out_valid && !out_ready, out_data, out_sat and out_valid hold stable. Stage 1 holds. in_ready=0 once both stages are full. No beat is dropped or duplicated.
- beat_cnt: increments by 1 on each output handshake and wraps from 2^CNTW-1 to 0. Cleared only by reset.
- busy = s1_valid || out_valid.
- Scale edge cases:
  - cfg_scale=0 gives all-zero lanes, no saturation.
  - cfg_scale=2^FRAC is identity regardless of cfg_round.
- Reset asserted mid-operation: all in-flight beats are discarded and all outputs return to reset values immediately (asynchronous).

Test Plan:
- Truncate vs round: LANES=8, FRAC=8, cfg_scale=45, x=255 on all lanes, out_ready=1. cfg_round=0 -> all lanes 44. cfg_round=1 -> all lanes 45. x=200 gives 35 in both modes. out_valid rises exactly 2 edges after acceptance.
- Saturation: cfg_scale=0x200 (2.0), lanes {0,1,100,127,128,200,254,255} -> out {0,2,200,254,255,255,255,255}; out_sat=8'b11110000 (lanes 4-7 set).
- Backpressure: stream 6 beats (lane value = beat index) with out_ready low for cycles 3-7. in_ready drops after 2 beats are buffered; out_data stays stable while stalled; all 6 beats emerge in order; beat_cnt=6.
- Mid-stream config change: cfg_scale 256 for beat A (x=10), 128 for beat B (x=10), issued back-to-back -> outputs 10 then 5.
- Counter wrap: CNTW=4, 17 handshakes -> beat_cnt=1. busy=0 when drained.
- Async reset with two beats in flight and out_ready=0 -> out_valid=0, beat_cnt=0, busy=0 immediately; in_ready=1 after release.
